// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_pkg
// Purpose  : Shared definitions for the load/store sequencer: request size
//            codes, FSM state encoding, big-endian lane positions and a lane
//            helper used by both the sequencer and the lane aligner.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // Request size codes as presented on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Sequencer state encoding
    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RD   = 2'd1;
    localparam logic [STATE_W-1:0] ST_WR   = 2'd2;
    localparam logic [STATE_W-1:0] ST_RESP = 2'd3;

    // Big-endian byte lanes: lowest address holds the most significant byte.
    // Values are the LSB bit position of each byte lane inside a word.
    localparam logic [4:0] LANE0_LSB = 5'd24;
    localparam logic [4:0] LANE1_LSB = 5'd16;
    localparam logic [4:0] LANE2_LSB = 5'd8;
    localparam logic [4:0] LANE3_LSB = 5'd0;

    // LSB position of the byte at word offset off. A halfword at offset
    // {off[1],0} occupies the byte at {off[1],1} plus the one above it, so
    // the same helper serves halfwords when called with {off[1],1'b1}.
    function automatic logic [4:0] lane_lsb(input logic [1:0] off);
        logic [4:0] lsb;
        case (off)
            2'd0:    lsb = LANE0_LSB;
            2'd1:    lsb = LANE1_LSB;
            2'd2:    lsb = LANE2_LSB;
            default: lsb = LANE3_LSB;
        endcase
        return lsb;
    endfunction

    // Alignment/size legality, independent of address range
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'd0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_lane_align
// Purpose  : Combinational big-endian lane handling for sub-word accesses.
//            Extraction: picks the addressed byte/half out of a memory word
//            and sign- or zero-extends it (word loads pass straight through).
//            Merge: replaces the addressed lane of a memory word with the
//            right-justified store data (word stores take the data whole).
// Ports    : i_word   - memory word being read
//            i_off    - byte offset within the word
//            i_size   - access size code
//            i_signed - sign-extend sub-word loads
//            i_wdata  - right-justified store data
//            o_load   - extended load result
//            o_merged - word with the target lane replaced
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]  w_byte_lsb;
    logic [4:0]  w_half_lsb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte_lsb = lane_lsb(i_off);
        w_half_lsb = lane_lsb({i_off[1], 1'b1});
        w_byte     = 8'(i_word >> w_byte_lsb);
        w_half     = 16'(i_word >> w_half_lsb);

        o_load   = '0;
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_load   = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merged = (i_word & ~(32'h0000_00FF << w_byte_lsb)) |
                           ({24'b0, i_wdata[7:0]} << w_byte_lsb);
            end
            SZ_HALF: begin
                o_load   = {{16{i_signed & w_half[15]}}, w_half};
                o_merged = (i_word & ~(32'h0000_FFFF << w_half_lsb)) |
                           ({16'b0, i_wdata[15:0]} << w_half_lsb);
            end
            SZ_WORD: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
            default: begin
                o_load   = '0;
                o_merged = i_word;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store sequencer between the datapath and a big-endian,
//            byte-addressed word memory (combinational read, clocked write).
//            Issues aligned word accesses; sub-word stores are performed as
//            read-modify-write. Misaligned, illegal-size and out-of-range
//            requests complete with an error and never write memory.
// Ports    : clk, reset (async, active-low)
//            req_*  - request channel from the datapath (req_ready out)
//            mem_*  - memory port (mem_a/mem_wd/mem_we out, mem_rd in)
//            resp_* - one-cycle completion pulse with load data and error
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [32:0] c_LAST_BYTE = 33'(MEM_BYTES - 1);

    // Latched request
    logic [STATE_W-1:0] r_state;
    logic               r_write;
    logic [1:0]         r_size;
    logic               r_signed;
    logic [1:0]         r_off;
    logic [31:0]        r_wdata;

    // Registered outputs
    logic               r_req_ready;
    logic [31:0]        r_mem_a;
    logic [31:0]        r_mem_wd;
    logic               r_mem_we;
    logic               r_resp_valid;
    logic [31:0]        r_resp_rdata;
    logic               r_resp_err;

    // Request decode at acceptance
    logic [31:0]        w_aligned;
    logic [1:0]         w_off;
    logic               w_range_err;
    logic               w_err;
    logic               w_accept;

    // Lane aligner results (valid while in RD, fed by the live read word)
    logic [31:0]        w_load;
    logic [31:0]        w_merged;

    assign w_aligned   = {req_addr[31:2], 2'b00};
    assign w_off       = req_addr[1:0];
    // Widened by one bit so the +3 can never wrap past zero
    assign w_range_err = ({1'b0, w_aligned} + 33'd3) > c_LAST_BYTE;
    assign w_err       = misaligned(req_size, w_off) || w_range_err;
    assign w_accept    = req_valid && r_req_ready;

    // The read word is consumed at the RD edge directly: the load result
    // goes to resp_rdata and the merged word goes to mem_wd, so both are
    // registered in time for the following RESP or WR cycle.
    mem_access_unit_lane_align u_lane_align (
        .i_word   (mem_rd),
        .i_off    (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Asynchronous clear drops mem_we at once, so a store in flight
            // cannot complete after reset.
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
            r_off        <= 2'd0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_mem_a      <= '0;
            r_mem_wd     <= '0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_off       <= w_off;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_err) begin
                            // mem_a deliberately keeps its previous value
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_mem_a <= w_aligned;
                            if (req_write && (req_size == SZ_WORD)) begin
                                r_state  <= ST_WR;
                                r_mem_wd <= req_wdata;
                                r_mem_we <= 1'b1;
                            end else begin
                                r_state <= ST_RD;
                            end
                        end
                    end
                end

                ST_RD: begin
                    if (r_write) begin
                        r_state  <= ST_WR;
                        r_mem_wd <= w_merged;
                        r_mem_we <= 1'b1;
                    end else begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                        r_resp_err   <= 1'b0;
                    end
                end

                ST_WR: begin
                    r_state      <= ST_RESP;
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                end

                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b1;
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_a      = r_mem_a;
    assign mem_wd     = r_mem_wd;
    assign mem_we     = r_mem_we;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit with a big-endian byte
//            memory model, a table of directed requests and a hand-written
//            reset-during-store sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int unsigned MEM_BYTES = 101;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int tests;
    int fails;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian byte memory: combinational read, write on the clock edge
    logic [7:0]  mem [0:127];
    logic [6:0]  a0;
    int          we_cnt;
    int          resp_cnt;
    logic [31:0] we_addr;

    assign a0     = mem_a[6:0];
    assign mem_rd = {mem[a0], mem[a0 + 7'd1], mem[a0 + 7'd2], mem[a0 + 7'd3]};

    always @(posedge clk) begin
        if (mem_we) begin
            mem[a0]        <= mem_wd[31:24];
            mem[a0 + 7'd1] <= mem_wd[23:16];
            mem[a0 + 7'd2] <= mem_wd[15:8];
            mem[a0 + 7'd3] <= mem_wd[7:0];
            we_cnt         <= we_cnt + 1;
            we_addr        <= mem_a;
        end
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    localparam int NV = 23;
    vec_t v [NV];

    // Issue one request and measure it. Latency counts clock edges starting
    // with the accept edge up to the one that raises resp_valid.
    task automatic run_req(input vec_t t, input int idx);
        int          lat;
        int          we0;
        logic [31:0] rd;
        logic        er;
        string       tag;
        tag = $sformatf("v%0d", idx);
        check({tag, ".ready_before"}, {31'b0, req_ready}, 32'd1);
        we0        = we_cnt;
        req_valid  = 1'b1;
        req_write  = t.wr;
        req_size   = t.sz;
        req_signed = t.sg;
        req_addr   = t.addr;
        req_wdata  = t.wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        if (!resp_valid) begin
            tests++; fails++;
            $display("FAIL %s.timeout: got no resp_valid within %0d edges required a response", tag, lat);
        end
        check({tag, ".rdata"},   rd, t.exp_rd);
        check({tag, ".err"},     {31'b0, er}, {31'b0, t.exp_err});
        check({tag, ".latency"}, 32'(lat), 32'(t.exp_lat));
        check({tag, ".we_cnt"},  32'(we_cnt - we0), 32'(t.exp_we));
        if (t.exp_we != 0)
            check({tag, ".we_addr"}, we_addr, {t.addr[31:2], 2'b00});
        @(posedge clk); #1;
        check({tag, ".pulse_one"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        we_cnt    = 0;
        resp_cnt  = 0;
        we_addr   = '0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        //         wr    sz     sg    addr   wdata          exp_rd         err  lat we
        v[0]  = '{1'b1, 2'b10, 1'b0, 32'd8,  32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1}; // sw
        v[1]  = '{1'b0, 2'b10, 1'b0, 32'd8,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0}; // lw
        v[2]  = '{1'b1, 2'b10, 1'b0, 32'd8,  32'h80FF7F01, 32'h00000000, 1'b0, 2, 1}; // sw
        v[3]  = '{1'b0, 2'b00, 1'b1, 32'd8,  32'h0,        32'hFFFFFF80, 1'b0, 2, 0}; // lb
        v[4]  = '{1'b0, 2'b00, 1'b0, 32'd8,  32'h0,        32'h00000080, 1'b0, 2, 0}; // lbu
        v[5]  = '{1'b0, 2'b00, 1'b1, 32'd10, 32'h0,        32'h0000007F, 1'b0, 2, 0}; // lb
        v[6]  = '{1'b0, 2'b00, 1'b1, 32'd9,  32'h0,        32'hFFFFFFFF, 1'b0, 2, 0}; // lb
        v[7]  = '{1'b0, 2'b01, 1'b1, 32'd8,  32'h0,        32'hFFFF80FF, 1'b0, 2, 0}; // lh
        v[8]  = '{1'b0, 2'b01, 1'b0, 32'd10, 32'h0,        32'h00007F01, 1'b0, 2, 0}; // lhu
        v[9]  = '{1'b0, 2'b10, 1'b1, 32'd8,  32'h0,        32'h80FF7F01, 1'b0, 2, 0}; // lw signed ignored
        v[10] = '{1'b1, 2'b10, 1'b0, 32'd12, 32'h11223344, 32'h00000000, 1'b0, 2, 1}; // sw
        v[11] = '{1'b1, 2'b00, 1'b0, 32'd13, 32'h000000AA, 32'h00000000, 1'b0, 3, 1}; // sb
        v[12] = '{1'b0, 2'b10, 1'b0, 32'd12, 32'h0,        32'h11AA3344, 1'b0, 2, 0}; // lw
        v[13] = '{1'b1, 2'b01, 1'b0, 32'd14, 32'h0000BEEF, 32'h00000000, 1'b0, 3, 1}; // sh
        v[14] = '{1'b0, 2'b10, 1'b0, 32'd12, 32'h0,        32'h11AABEEF, 1'b0, 2, 0}; // lw
        v[15] = '{1'b1, 2'b00, 1'b0, 32'd15, 32'hFFFFFF23, 32'h00000000, 1'b0, 3, 1}; // sb upper bits ignored
        v[16] = '{1'b0, 2'b10, 1'b0, 32'd12, 32'h0,        32'h11AABE23, 1'b0, 2, 0}; // lw
        v[17] = '{1'b0, 2'b01, 1'b1, 32'd9,  32'h0,        32'h00000000, 1'b1, 1, 0}; // lh misaligned
        v[18] = '{1'b1, 2'b10, 1'b0, 32'd6,  32'h12345678, 32'h00000000, 1'b1, 1, 0}; // sw misaligned
        v[19] = '{1'b0, 2'b10, 1'b0, 32'd100,32'h0,        32'h00000000, 1'b1, 1, 0}; // lw out of range
        v[20] = '{1'b1, 2'b11, 1'b0, 32'd0,  32'hCAFEF00D, 32'h00000000, 1'b1, 1, 0}; // illegal size
        v[21] = '{1'b1, 2'b10, 1'b0, 32'd96, 32'h01020304, 32'h00000000, 1'b0, 2, 1}; // last legal word
        v[22] = '{1'b0, 2'b00, 1'b0, 32'd99, 32'h0,        32'h00000004, 1'b0, 2, 0}; // lbu last byte

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.req_ready",  {31'b0, req_ready},  32'd1);
        check("rst.mem_we",     {31'b0, mem_we},     32'd0);
        check("rst.mem_a",      mem_a,               32'd0);
        check("rst.mem_wd",     mem_wd,              32'd0);
        check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata,          32'd0);
        check("rst.resp_err",   {31'b0, resp_err},   32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) run_req(v[i], i);

        // Reset in the RD cycle of a byte store to word 12
        begin
            int we0;
            int rc0;
            we0        = we_cnt;
            rc0        = resp_cnt;
            req_valid  = 1'b1;
            req_write  = 1'b1;
            req_size   = 2'b00;
            req_signed = 1'b0;
            req_addr   = 32'd12;
            req_wdata  = 32'h00000055;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("mid.ready_busy", {31'b0, req_ready}, 32'd0);
            #2;
            reset = 1'b0;
            #1;
            check("mid.we_now",    {31'b0, mem_we},     32'd0);
            check("mid.resp_now",  {31'b0, resp_valid}, 32'd0);
            check("mid.ready_now", {31'b0, req_ready},  32'd1);
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            check("mid.no_write", 32'(we_cnt - we0), 32'd0);
            check("mid.no_resp",  32'(resp_cnt - rc0), 32'd0);
            check("mid.word12", {mem[12], mem[13], mem[14], mem[15]}, 32'h11AABE23);
            check("mid.ready_after", {31'b0, req_ready}, 32'd1);
        end

        // Normal service resumes after reset
        run_req('{1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 32'h11AABE23, 1'b0, 2, 0}, 100);
        run_req('{1'b1, 2'b00, 1'b0, 32'd12, 32'h55, 32'h0, 1'b0, 3, 1}, 101);
        run_req('{1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 32'h55AABE23, 1'b0, 2, 0}, 102);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
